adbg_jtag_tap: RTL and testbench

//  IEEE 1149.1 TAP controller that drives the adbg top-level debug chain. It decodes TMS into
//  the 16-state TAP FSM, holds the instruction register, and implements IDCODE and BYPASS data

---
 rtl/adbg_jtag_tap.sv | 175 +++++++++++++++++
 tb/tb_adbg_jtag_tap.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/adbg_jtag_tap.sv
//==============================================================================
// Module   : adbg_jtag_tap
// Brief    : IEEE 1149.1 TAP controller for the adbg debug chain. Decodes TMS
//            into the 16-state TAP FSM, holds the instruction register, and
//            implements the IDCODE and BYPASS data registers. Emits DR-state
//            strobes and debug_select_o, and muxes the final TDO.
// Config   : ADBG_TAP_IDCODE_EN - when defined, the IDCODE DR is built and
//            IDCODE_INSTR is the reset instruction; otherwise IDCODE_INSTR
//            falls through to BYPASS and BYPASS_INSTR is the reset instruction.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module adbg_jtag_tap #(
    parameter int unsigned        IR_LEN       = 4,
    parameter logic [31:0]        IDCODE_VALUE = 32'h149511C3,
    parameter logic [IR_LEN-1:0]  IDCODE_INSTR = 'h2,
    parameter logic [IR_LEN-1:0]  DEBUG_INSTR  = 'h8,
    parameter logic [IR_LEN-1:0]  BYPASS_INSTR = 'hF
) (
    input  logic tck_i,
    input  logic trstn_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    input  logic debug_tdo_i,
    output logic test_logic_reset_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic debug_select_o
);

    typedef enum logic [3:0] {
        S_TLR    = 4'd0,  S_RTI    = 4'd1,
        S_SEL_DR = 4'd2,  S_CAP_DR = 4'd3,  S_SH_DR = 4'd4,  S_EX1_DR = 4'd5,
        S_PA_DR  = 4'd6,  S_EX2_DR = 4'd7,  S_UPD_DR = 4'd8,
        S_SEL_IR = 4'd9,  S_CAP_IR = 4'd10, S_SH_IR = 4'd11, S_EX1_IR = 4'd12,
        S_PA_IR  = 4'd13, S_EX2_IR = 4'd14, S_UPD_IR = 4'd15
    } tap_state_t;

    // Value loaded by Capture-IR: binary ...01 as 1149.1 requires.
    localparam logic [IR_LEN-1:0] c_IR_CAPTURE = IR_LEN'(1);
`ifdef ADBG_TAP_IDCODE_EN
    localparam logic [IR_LEN-1:0] c_RESET_INSTR = IDCODE_INSTR;
`else
    localparam logic [IR_LEN-1:0] c_RESET_INSTR = BYPASS_INSTR;
`endif

    // Elaboration-time sanity checks on the parameter set.
    generate
        if (IR_LEN < 2 || IDCODE_VALUE[0] != 1'b1 || IDCODE_INSTR == DEBUG_INSTR) begin : g_param_check
            $error("adbg_jtag_tap: illegal parameter set");
        end
    endgenerate

    tap_state_t        r_state;
    tap_state_t        w_state_nxt;
    logic [IR_LEN-1:0] r_ir_shift;
    logic [IR_LEN-1:0] r_latched_ir;
    logic              r_bypass;
    logic              r_tdo;
    logic              r_tdo_oe;
    logic              w_debug_sel;
    logic              w_idcode_sel;
    logic              w_idcode_tdo;
    logic              w_tdo_mux;

    // TAP state register.
    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) r_state <= S_TLR;
        else          r_state <= w_state_nxt;
    end

    // 1149.1 next-state decode from TMS.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_TLR:    w_state_nxt = tms_i ? S_TLR    : S_RTI;
            S_RTI:    w_state_nxt = tms_i ? S_SEL_DR : S_RTI;
            S_SEL_DR: w_state_nxt = tms_i ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: w_state_nxt = tms_i ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  w_state_nxt = tms_i ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: w_state_nxt = tms_i ? S_UPD_DR : S_PA_DR;
            S_PA_DR:  w_state_nxt = tms_i ? S_EX2_DR : S_PA_DR;
            S_EX2_DR: w_state_nxt = tms_i ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: w_state_nxt = tms_i ? S_SEL_DR : S_RTI;
            S_SEL_IR: w_state_nxt = tms_i ? S_TLR    : S_CAP_IR;
            S_CAP_IR: w_state_nxt = tms_i ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  w_state_nxt = tms_i ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: w_state_nxt = tms_i ? S_UPD_IR : S_PA_IR;
            S_PA_IR:  w_state_nxt = tms_i ? S_EX2_IR : S_PA_IR;
            S_EX2_IR: w_state_nxt = tms_i ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: w_state_nxt = tms_i ? S_SEL_DR : S_RTI;
            default:  w_state_nxt = S_TLR;
        endcase
    end

    assign test_logic_reset_o = (r_state == S_TLR);
    assign capture_dr_o       = (r_state == S_CAP_DR);
    assign shift_dr_o         = (r_state == S_SH_DR);
    assign pause_dr_o         = (r_state == S_PA_DR);
    assign update_dr_o        = (r_state == S_UPD_DR);

    // IR shift path and latched instruction; TLR keeps reloading the reset opcode.
    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            r_ir_shift   <= '0;
            r_latched_ir <= c_RESET_INSTR;
        end else begin
            if (r_state == S_CAP_IR)     r_ir_shift <= c_IR_CAPTURE;
            else if (r_state == S_SH_IR) r_ir_shift <= {tdi_i, r_ir_shift[IR_LEN-1:1]};
            if (r_state == S_TLR)         r_latched_ir <= c_RESET_INSTR;
            else if (r_state == S_UPD_IR) r_latched_ir <= r_ir_shift;
        end
    end

    assign w_debug_sel    = (r_latched_ir == DEBUG_INSTR);
    assign debug_select_o = w_debug_sel;

`ifdef ADBG_TAP_IDCODE_EN
    logic [31:0] r_idcode;

    assign w_idcode_sel = (r_latched_ir == IDCODE_INSTR);
    assign w_idcode_tdo = r_idcode[0];

    // IDCODE DR: capture the constant, then shift LSB-first.
    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i)                                r_idcode <= '0;
        else if (w_idcode_sel && r_state == S_CAP_DR) r_idcode <= IDCODE_VALUE;
        else if (w_idcode_sel && r_state == S_SH_DR)  r_idcode <= {tdi_i, r_idcode[31:1]};
    end
`else
    assign w_idcode_sel = 1'b0;
    assign w_idcode_tdo = 1'b0;
`endif

    // Single-bit BYPASS register.
    always_ff @(posedge tck_i or negedge trstn_i) begin
        if (!trstn_i)                r_bypass <= 1'b0;
        else if (r_state == S_CAP_DR) r_bypass <= 1'b0;
        else if (r_state == S_SH_DR)  r_bypass <= tdi_i;
    end

    // TDO source select; the debug chain wins over the local DRs.
    always_comb begin
        w_tdo_mux = 1'b0;
        if (r_state == S_SH_IR) begin
            w_tdo_mux = r_ir_shift[0];
        end else if (r_state == S_SH_DR) begin
            if (w_debug_sel)       w_tdo_mux = debug_tdo_i;
            else if (w_idcode_sel) w_tdo_mux = w_idcode_tdo;
            else                   w_tdo_mux = r_bypass;
        end
    end

    // TDO and its enable change on the falling edge so the host samples a stable bit.
    always_ff @(negedge tck_i or negedge trstn_i) begin
        if (!trstn_i) begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else begin
            r_tdo    <= w_tdo_mux;
            r_tdo_oe <= (r_state == S_SH_IR) || (r_state == S_SH_DR);
        end
    end

    assign tdo_o    = r_tdo;
    assign tdo_oe_o = r_tdo_oe;

endmodule

`default_nettype wire

// File: tb/tb_adbg_jtag_tap.sv
//==============================================================================
// Module   : tb_adbg_jtag_tap
// Brief    : Directed self-checking bench for adbg_jtag_tap.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_adbg_jtag_tap;

`ifdef ADBG_TAP_IDCODE_EN
    localparam logic [31:0] c_RESET_SCAN = 32'h149511C3;
`else
    localparam logic [31:0] c_RESET_SCAN = 32'h0000_0000;
`endif

    logic tck = 1'b0;
    logic trstn_i, tms_i, tdi_i, debug_tdo_i;
    logic tdo_o, tdo_oe_o, test_logic_reset_o;
    logic capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o, debug_select_o;

    int n_checks = 0;
    int n_pass   = 0;

    adbg_jtag_tap u_dut (
        .tck_i              (tck),
        .trstn_i            (trstn_i),
        .tms_i              (tms_i),
        .tdi_i              (tdi_i),
        .tdo_o              (tdo_o),
        .tdo_oe_o           (tdo_oe_o),
        .debug_tdo_i        (debug_tdo_i),
        .test_logic_reset_o (test_logic_reset_o),
        .capture_dr_o       (capture_dr_o),
        .shift_dr_o         (shift_dr_o),
        .pause_dr_o         (pause_dr_o),
        .update_dr_o        (update_dr_o),
        .debug_select_o     (debug_select_o)
    );

    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] strobes();
        return {28'd0, capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o};
    endfunction

    // One TCK: drive TMS/TDI, take the rising edge, then sample after the falling edge.
    task automatic step(input logic t, input logic d);
        tms_i = t;
        tdi_i = d;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // From RTI: full IR scan; returns captured bits and debug_select seen mid-shift.
    task automatic load_ir(input logic [3:0] v, output logic [3:0] cap, output logic sel_mid);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        cap = '0;
        sel_mid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cap[i] = tdo_o;
            if (i == 2) sel_mid = debug_select_o;
            step(i == 3, v[i]);
        end
        step(1, 0); step(0, 0);
    endtask

    // From RTI: n-bit DR scan, returns collected TDO bits and whether OE tracked Shift-DR.
    task automatic scan_dr(input int n, input logic [31:0] d, output logic [31:0] got, output logic oe_ok);
        step(1, 0); step(0, 0); step(0, 0);
        got = '0;
        oe_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            got[i] = tdo_o;
            if (!tdo_oe_o) oe_ok = 1'b0;
            step(i == n - 1, d[i]);
        end
        if (tdo_oe_o) oe_ok = 1'b0;
        step(1, 0); step(0, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic [3:0]  cap;
        logic        oe_ok, sel_mid;
        logic [7:0]  pat;

        trstn_i = 1'b0; tms_i = 1'b1; tdi_i = 1'b0; debug_tdo_i = 1'b0;
        #12;
        check("rst_tlr",     32'(test_logic_reset_o), 32'd1);
        check("rst_strobes", strobes(),                32'd0);
        check("rst_tdo",     32'(tdo_o),               32'd0);
        check("rst_oe",      32'(tdo_oe_o),            32'd0);
        check("rst_dbgsel",  32'(debug_select_o),      32'd0);
        @(negedge tck); #1;
        trstn_i = 1'b1;

        // First DR scan after reset: IDCODE, or the bypass zeros without it.
        step(0, 0);
        scan_dr(32, 32'd0, got, oe_ok);
        check("reset_scan",    got,          c_RESET_SCAN);
        check("reset_scan_oe", 32'(oe_ok),   32'd1);

        // IR capture pattern, then BYPASS delays data by one bit.
        load_ir(4'hF, cap, sel_mid);
        check("ir_capture", 32'(cap), 32'h1);
        scan_dr(8, 32'hA5, got, oe_ok);
        check("bypass_scan",    got,        32'h4A);
        check("bypass_scan_oe", 32'(oe_ok), 32'd1);

        // DEBUG instruction: TDO follows debug_tdo_i, strobes per state.
        load_ir(4'h8, cap, sel_mid);
        check("dbg_select", 32'(debug_select_o), 32'd1);
        step(1, 0); step(0, 0);
        check("cap_dr_strobe", strobes(), 32'b1000);
        step(0, 0);
        check("sh_dr_strobe", strobes(), 32'b0100);
        check("sh_dr_oe",     32'(tdo_oe_o), 32'd1);
        pat = 8'h69;
        got = '0;
        for (int i = 0; i < 8; i++) begin
            debug_tdo_i = pat[i];
            step(0, 0);
            got[i] = tdo_o;
        end
        check("dbg_tdo_follow", got, 32'h69);
        debug_tdo_i = 1'b1;
        step(1, 0);
        check("ex1_dr_strobe", strobes(), 32'b0000);
        step(0, 0);
        check("pa_dr_strobe", strobes(), 32'b0010);
        check("pa_dr_oe",     32'(tdo_oe_o), 32'd0);
        check("pa_dr_tdo",    32'(tdo_o),    32'd0);
        step(0, 0);
        check("pa_dr_hold", strobes(), 32'b0010);
        step(1, 0); step(1, 0);
        check("upd_dr_strobe", strobes(), 32'b0001);
        step(0, 0);
        check("rti_strobe", strobes(), 32'b0000);
        debug_tdo_i = 1'b0;

        // Latched IR holds through Shift-IR until Update-IR.
        load_ir(4'hF, cap, sel_mid);
        check("ir_hold_mid",  32'(sel_mid),        32'd1);
        check("ir_upd_new",   32'(debug_select_o), 32'd0);

        // Five TMS=1 edges from Shift-DR reach TLR; sixth reloads the reset opcode.
        load_ir(4'h8, cap, sel_mid);
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 4; i++) step(1, 0);
        check("tlr_after4", 32'(test_logic_reset_o), 32'd0);
        step(1, 0);
        check("tlr_after5", 32'(test_logic_reset_o), 32'd1);
        step(1, 0);
        check("tlr_after6",   32'(test_logic_reset_o), 32'd1);
        check("tlr_ir_reset", 32'(debug_select_o),     32'd0);
        step(0, 0);
        scan_dr(32, 32'd0, got, oe_ok);
        check("tlr_scan", got, c_RESET_SCAN);

        // From RTI, exactly five TMS=1 edges.
        for (int i = 0; i < 5; i++) step(1, 0);
        check("rti_5_tlr", 32'(test_logic_reset_o), 32'd1);
        step(0, 0);

        // Async reset during the 10th shift bit.
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 9; i++) step(0, 0);
        check("pre_abort_oe", 32'(tdo_oe_o), 32'd1);
        #2;
        trstn_i = 1'b0;
        #1;
        check("abort_tlr",     32'(test_logic_reset_o), 32'd1);
        check("abort_tdo",     32'(tdo_o),              32'd0);
        check("abort_oe",      32'(tdo_oe_o),           32'd0);
        check("abort_strobes", strobes(),               32'd0);
        @(negedge tck); #1;
        trstn_i = 1'b1;
        step(0, 0);
        scan_dr(32, 32'd0, got, oe_ok);
        check("abort_rescan", got, c_RESET_SCAN);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
